fa_norm_round: RTL and testbench

Parametrised normalise-and-round stage for the floating-point adder/MAC datapath; successor to the fixed 8/23 final adder step. It takes the raw aligned sum, sign and pre-normalisation exponent, and finds the leading one itself (no external count). It applies IEEE round-to-nearest-even using guard/round/sticky and packs sign, exponent and significand with overflow/underflow/zero/inexact flags. Two-stage pipeline with valid/ready backpressure; sits between the adder core and the MAC accumulator register.

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_lzc.sv | 31 +++
 rtl/fa_norm_round.sv | 215 +++++++++++++++++++++
 tb/tb_fa_norm_round.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared floating-point datapath definitions: default field widths, the bit
// positions of the result flag vector and a packed result record.
// No ports (package).
// ---------------------------------------------------------------------------
package fp_pkg;

    // Default single-precision style field widths.
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // Result flag vector layout: {zero, ovf, unf, inexact}.
    localparam int FLAGS_W   = 4;
    localparam int FLAG_ZERO = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_INX  = 0;

    // Packed result for the default widths.
    typedef struct packed {
        logic                 s;
        logic [EXP_W_DEF-1:0] ex;
        logic [MAN_W_DEF:0]   sg;
        logic [FLAGS_W-1:0]   flags;
    } fp_result_t;

endpackage

// File: rtl/fp_lzc.sv
// ---------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter.
// Ports:
//   data_i  [W-1:0]      vector to scan, MSB first
//   count_o [CNT_W-1:0]  number of zeros above the most significant one
//                        (W when the vector is all zero)
//   zero_o               vector is all zero
// ---------------------------------------------------------------------------
module fp_lzc #(
    parameter int W     = 26,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     data_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        count_o = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (data_i[i]) begin
                count_o = CNT_W'(W - 1 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/fa_norm_round.sv
// ---------------------------------------------------------------------------
// fa_norm_round
// Normalise-and-round stage of the FP adder / MAC datapath. Finds the leading
// one of the raw aligned sum, normalises, rounds to nearest-even using
// guard/round/sticky, and packs the result with exception flags.
// Pipeline: normalise register -> round register -> registered outputs, so a
// beat accepted at edge N is presented after edge N+2. One global stall
// (out_valid & ~out_ready) freezes every rank.
// Ports:
//   CLK, RESETn          clock, synchronous active-low reset
//   in_valid / in_ready  input handshake
//   in_sign              sign of the sum
//   in_ex     [EXP_W]    biased exponent of the integer bit in_sum[SUM_W-2]
//   in_sum    [SUM_W]    {carry, integer, fraction, guard, round}
//   in_sticky            OR of alignment bits below round
//   out_valid/out_ready  output handshake
//   out_s, out_ex, out_sg {hidden, fraction}, out_flags {zero,ovf,unf,inexact}
// ---------------------------------------------------------------------------
module fa_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_W-1:0]   in_ex,
    input  logic [MAN_W+3:0]   in_sum,
    input  logic               in_sticky,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_s,
    output logic [EXP_W-1:0]   out_ex,
    output logic [MAN_W:0]     out_sg,
    output logic [FLAGS_W-1:0] out_flags
);

    localparam int SUM_W = MAN_W + 4;          // carry + integer + frac + G + R
    localparam int NRM_W = SUM_W - 1;          // integer + frac + G + R
    localparam int SIG_W = MAN_W + 1;          // hidden + frac
    localparam int IEX_W = EXP_W + 2;          // signed, wide enough not to wrap
    localparam int LZ_W  = $clog2(NRM_W + 1);

    localparam logic signed [IEX_W-1:0] EX_ONE  = IEX_W'(1);
    localparam logic signed [IEX_W-1:0] EX_ZERO = '0;
    localparam logic signed [IEX_W-1:0] EX_MAX  = IEX_W'((1 << EXP_W) - 1);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // -----------------------------------------------------------------------
    // Stage 1: normalise
    // -----------------------------------------------------------------------
    logic [LZ_W-1:0]         lz;
    logic                    nrm_all_zero;
    logic signed [IEX_W-1:0] ex_in;

    fp_lzc #(
        .W     (NRM_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .data_i  (in_sum[NRM_W-1:0]),
        .count_o (lz),
        .zero_o  (nrm_all_zero)
    );

    assign ex_in = {2'b00, in_ex};

    logic                    s1_valid_q,  s1_valid_d;
    logic                    s1_sign_q,   s1_sign_d;
    logic signed [IEX_W-1:0] s1_ex_q,     s1_ex_d;
    logic [NRM_W-1:0]        s1_man_q,    s1_man_d;
    logic                    s1_sticky_q, s1_sticky_d;
    logic                    s1_zero_q,   s1_zero_d;

    always_comb begin
        s1_valid_d  = in_valid;
        s1_sign_d   = in_sign;
        // lz is 0 when the integer bit is set, so this also covers pass-through.
        s1_man_d    = in_sum[NRM_W-1:0] << lz;
        s1_ex_d     = ex_in - $signed(IEX_W'(lz));
        s1_sticky_d = in_sticky;
        if (in_sum[SUM_W-1]) begin
            // Carry out of the adder: the dropped round bit folds into sticky.
            s1_man_d    = in_sum[SUM_W-1:1];
            s1_sticky_d = in_sticky | in_sum[0];
            s1_ex_d     = ex_in + EX_ONE;
        end
        s1_zero_d = ~in_sum[SUM_W-1] & nrm_all_zero;
    end

    // -----------------------------------------------------------------------
    // Stage 2: round to nearest, ties to even
    // -----------------------------------------------------------------------
    logic                    s2_valid_q,   s2_valid_d;
    logic                    s2_sign_q,    s2_sign_d;
    logic signed [IEX_W-1:0] s2_ex_q,      s2_ex_d;
    logic [SIG_W-1:0]        s2_sig_q,     s2_sig_d;
    logic                    s2_inexact_q, s2_inexact_d;
    logic                    s2_zero_q,    s2_zero_d;

    logic             rnd_g, rnd_r, rnd_lsb, rnd_inc;
    logic [SIG_W:0]   rnd_sum;

    always_comb begin
        rnd_g   = s1_man_q[1];
        rnd_r   = s1_man_q[0];
        rnd_lsb = s1_man_q[2];
        rnd_inc = rnd_g & (rnd_r | s1_sticky_q | rnd_lsb);
        rnd_sum = {1'b0, s1_man_q[NRM_W-1:2]} + (SIG_W + 1)'(rnd_inc);

        s2_valid_d   = s1_valid_q;
        s2_sign_d    = s1_sign_q;
        s2_zero_d    = s1_zero_q;
        s2_inexact_d = rnd_g | rnd_r | s1_sticky_q;
        s2_ex_d      = s1_ex_q;
        s2_sig_d     = rnd_sum[SIG_W-1:0];
        if (rnd_sum[SIG_W]) begin
            // 1.111..1 + ulp: renormalise to 1.000..0 one binade up.
            s2_sig_d = {1'b1, {MAN_W{1'b0}}};
            s2_ex_d  = s1_ex_q + EX_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Output: exception handling and packing
    // -----------------------------------------------------------------------
    logic               out_valid_q, out_valid_d;
    logic               out_s_q,     out_s_d;
    logic [EXP_W-1:0]   out_ex_q,    out_ex_d;
    logic [SIG_W-1:0]   out_sg_q,    out_sg_d;
    logic [FLAGS_W-1:0] out_flags_q, out_flags_d;

    always_comb begin
        out_valid_d = s2_valid_q;
        out_s_d     = s2_sign_q;
        out_ex_d    = s2_ex_q[EXP_W-1:0];
        out_sg_d    = s2_sig_q;
        out_flags_d = '0;
        if (s2_zero_q) begin
            // Exact zero is always reported as +0.
            out_s_d                = 1'b0;
            out_ex_d               = '0;
            out_sg_d               = '0;
            out_flags_d[FLAG_ZERO] = 1'b1;
        end else if (s2_ex_q >= EX_MAX) begin
            out_ex_d               = '1;
            out_sg_d               = '0;
            out_flags_d[FLAG_OVF]  = 1'b1;
            out_flags_d[FLAG_INX]  = 1'b1;
        end else if (s2_ex_q <= EX_ZERO) begin
            // No subnormals: anything at or below exponent 0 flushes to zero.
            out_ex_d               = '0;
            out_sg_d               = '0;
            out_flags_d[FLAG_UNF]  = 1'b1;
            out_flags_d[FLAG_INX]  = 1'b1;
        end else begin
            out_flags_d[FLAG_INX]  = s2_inexact_q;
        end
    end

    // -----------------------------------------------------------------------
    // Pipeline registers: every rank advances together unless stalled.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_ex_q      <= '0;
            s1_man_q     <= '0;
            s1_sticky_q  <= 1'b0;
            s1_zero_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_ex_q      <= '0;
            s2_sig_q     <= '0;
            s2_inexact_q <= 1'b0;
            s2_zero_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_s_q      <= 1'b0;
            out_ex_q     <= '0;
            out_sg_q     <= '0;
            out_flags_q  <= '0;
        end else if (!stall) begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_ex_q      <= s1_ex_d;
            s1_man_q     <= s1_man_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_zero_q    <= s1_zero_d;
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_ex_q      <= s2_ex_d;
            s2_sig_q     <= s2_sig_d;
            s2_inexact_q <= s2_inexact_d;
            s2_zero_q    <= s2_zero_d;
            out_valid_q  <= out_valid_d;
            out_s_q      <= out_s_d;
            out_ex_q     <= out_ex_d;
            out_sg_q     <= out_sg_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_ex    = out_ex_q;
    assign out_sg    = out_sg_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fa_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fa_norm_round
// Self-checking bench for fa_norm_round (default 8/23 widths): directed cases,
// latency, backpressure, reset during stall, then randomized traffic checked
// against an integer-arithmetic reference model through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_fa_norm_round;
    import fp_pkg::*;

    logic        CLK       = 1'b0;
    logic        RESETn    = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_sign   = 1'b0;
    logic [7:0]  in_ex     = '0;
    logic [26:0] in_sum    = '0;
    logic        in_sticky = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_s;
    logic [7:0]  out_ex;
    logic [23:0] out_sg;
    logic [3:0]  out_flags;

    fa_norm_round #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_ex     (in_ex),
        .in_sum    (in_sum),
        .in_sticky (in_sticky),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_ex    (out_ex),
        .out_sg    (out_sg),
        .out_flags (out_flags)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    fp_result_t  exp_q[$];
    bit          last_acc   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [37:0] held;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic fp_result_t mk(input logic s, input logic [7:0] ex,
                                      input logic [23:0] sg, input logic [3:0] fl);
        fp_result_t r;
        r.s = s; r.ex = ex; r.sg = sg; r.flags = fl;
        return r;
    endfunction

    // Reference: the sum is an integer m scaled so bit 25 has exponent in_ex.
    // Take the top 24 bits below the leading one, round the exact remainder
    // (plus sticky) to nearest-even, then classify the resulting exponent.
    function automatic fp_result_t model(input logic sign, input logic [7:0] ex_in,
                                         input logic [26:0] sum, input logic sticky);
        longint m, q, rem, half;
        int     p, e;
        bit     up, inexact;
        m = longint'(sum);
        if (m == 0) return mk(1'b0, 8'h00, 24'h0, 4'b1000);
        p = 0;
        for (int i = 0; i < 27; i++) if (sum[i]) p = i;
        e = int'(ex_in) + p - 25;
        if (p >= 23) begin
            q   = m >> (p - 23);
            rem = m & ((longint'(1) << (p - 23)) - 1);
        end else begin
            q   = m << (23 - p);
            rem = 0;
        end
        half    = (p >= 24) ? (longint'(1) << (p - 24)) : 0;
        up      = (p >= 24) && ((rem > half) || (rem == half && (sticky || q[0])));
        inexact = (rem != 0) || sticky;
        if (up) q = q + 1;
        if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return mk(sign, 8'hFF, 24'h0, 4'b0101);
        if (e <= 0)   return mk(sign, 8'h00, 24'h0, 4'b0011);
        return mk(sign, e[7:0], q[23:0], {3'b000, inexact});
    endfunction

    // One clock: sample at negedge, then return #1 after the next posedge.
    task automatic tick();
        fp_result_t e, got;
        @(negedge CLK);
        if (RESETn) begin
            if (prev_stall)
                check_val("hold_stable", 64'({out_valid, out_s, out_ex, out_sg, out_flags}), 64'(held));
            check_val("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                got = mk(out_s, out_ex, out_sg, out_flags);
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    n_txn++;
                    $display("txn %0d: s=%0d ex=%02h sg=%06h flags=%04b (exp s=%0d ex=%02h sg=%06h flags=%04b)",
                             n_txn, out_s, out_ex, out_sg, out_flags, e.s, e.ex, e.sg, e.flags);
                    check_val("result", 64'(got), 64'(e));
                end
            end
            last_acc = in_valid && in_ready;
            if (last_acc) exp_q.push_back(model(in_sign, in_ex, in_sum, in_sticky));
            prev_stall = out_valid && !out_ready;
            held       = {out_valid, out_s, out_ex, out_sg, out_flags};
        end else begin
            last_acc   = 1'b0;
            prev_stall = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] ex,
                            input logic [26:0] sum, input logic st, input fp_result_t want);
        in_valid = 1'b1; in_sign = s; in_ex = ex; in_sum = sum; in_sticky = st;
        out_ready = 1'b1;
        tick();                                      // edge N: accepted
        check_val({tag, "_acc"}, 64'(last_acc), 64'(1));
        in_valid = 1'b0;
        tick();                                      // edge N+1
        check_val({tag, "_lat"}, 64'(out_valid), 64'(0));
        tick();                                      // edge N+2
        check_val({tag, "_vld"}, 64'(out_valid), 64'(1));
        check_val(tag, 64'(mk(out_s, out_ex, out_sg, out_flags)), 64'(want));
        tick();
    endtask

    function automatic logic [26:0] gen_sum();
        logic [26:0] v;
        case ($urandom_range(0, 5))
            0:       v = 27'($urandom);
            1:       v = 27'($urandom) >> $urandom_range(0, 26);
            2:       v = {2'b01, 25'($urandom)};
            3:       v = {1'b1, 26'($urandom)};
            4:       v = 27'h3FFFFFF - 27'($urandom_range(0, 7));
            default: v = ($urandom_range(0, 3) == 0) ? 27'h0 : 27'($urandom_range(1, 15));
        endcase
        return v;
    endfunction

    function automatic logic [7:0] gen_ex();
        case ($urandom_range(0, 2))
            0:       return 8'($urandom_range(0, 30));
            1:       return 8'($urandom_range(225, 255));
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic rand_beat();
        in_sign   = 1'($urandom_range(0, 1));
        in_ex     = gen_ex();
        in_sum    = gen_sum();
        in_sticky = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        RESETn = 1'b0;
        repeat (3) tick();
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_outputs", 64'({out_s, out_ex, out_sg, out_flags}), 64'(0));
        RESETn = 1'b1;
        tick();
        check_val("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed cases
        directed("carry_norm",  1'b0, 8'd127, 27'h4000000, 1'b0, mk(1'b0, 8'd128, 24'h800000, 4'b0000));
        directed("tie_even_up", 1'b0, 8'd127, 27'h2000006, 1'b0, mk(1'b0, 8'd127, 24'h800002, 4'b0001));
        directed("tie_even_dn", 1'b1, 8'd127, 27'h2000002, 1'b0, mk(1'b1, 8'd127, 24'h800000, 4'b0001));
        directed("tie_sticky",  1'b0, 8'd127, 27'h2000002, 1'b1, mk(1'b0, 8'd127, 24'h800001, 4'b0001));
        directed("rnd_carry",   1'b0, 8'd100, 27'h3FFFFFE, 1'b0, mk(1'b0, 8'd101, 24'h800000, 4'b0001));
        directed("cancel",      1'b0, 8'd130, 27'h0000004, 1'b0, mk(1'b0, 8'd107, 24'h800000, 4'b0000));
        directed("underflow",   1'b1, 8'd10,  27'h0000004, 1'b0, mk(1'b1, 8'd0,   24'h000000, 4'b0011));
        directed("overflow",    1'b0, 8'd254, 27'h4000000, 1'b0, mk(1'b0, 8'hFF,  24'h000000, 4'b0101));
        directed("rnd_to_ovf",  1'b1, 8'd254, 27'h3FFFFFE, 1'b0, mk(1'b1, 8'hFF,  24'h000000, 4'b0101));
        directed("max_normal",  1'b1, 8'd254, 27'h2000001, 1'b0, mk(1'b1, 8'd254, 24'h800000, 4'b0001));
        directed("zero",        1'b1, 8'd77,  27'h0000000, 1'b1, mk(1'b0, 8'd0,   24'h000000, 4'b1000));
        directed("sticky_only", 1'b0, 8'd127, 27'h2000000, 1'b1, mk(1'b0, 8'd127, 24'h800000, 4'b0001));
        directed("ex0_carry",   1'b0, 8'd0,   27'h4000000, 1'b0, mk(1'b0, 8'd1,   24'h800000, 4'b0000));
        directed("ex0_flush",   1'b0, 8'd0,   27'h2000000, 1'b0, mk(1'b0, 8'd0,   24'h000000, 4'b0011));

        // Backpressure: 3 back-to-back beats, sink stalled 5 cycles
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            rand_beat();
            tick();
            check_val("bp_accept", 64'(last_acc), 64'(1));
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("bp_in_ready_low", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check_val("bp_all_delivered", 64'(exp_q.size()), 64'(0));

        // Reset in the middle of a stall: nothing stale may come out
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            rand_beat();
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        RESETn = 1'b0;
        exp_q.delete();
        tick();
        check_val("rst_stall_out_valid", 64'(out_valid), 64'(0));
        RESETn    = 1'b1;
        out_ready = 1'b1;
        tick();
        check_val("rst_stall_in_ready", 64'(in_ready), 64'(1));
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val("rst_no_stale", 64'(out_valid), 64'(0));
        end

        // Randomized traffic with random backpressure; sender holds a beat
        // until it is accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || last_acc) begin
                if ($urandom_range(0, 9) < 7) begin
                    in_valid = 1'b1;
                    rand_beat();
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 6);
            tick();
        end

        // Drain with a bounded budget
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        check_val("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
